uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. It adds configurable clock/baud, data width, parity and stop bits, and an input FIFO so a host can queue several bytes without waiting for rdy. Frames leave LSB-first on TX and the line idles high. It sits between any byte producer (test-pattern generator, CPU bus bridge) and the board's serial pin.

Parameters:
CLK_FREQ, 24000000, system clock frequency in Hz
BAUD, 4800, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer, >=2; 5000 by default)
DATA_BITS, 8, payload bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, input FIFO entries, power of 2, >=2

Ports:
clk  input  1  system clock, rising edge
res  input  1  asynchronous reset, active-high
data_in  input  DATA_BITS  byte to enqueue
en_data_in  input  1  write strobe, sampled on each clk edge
full  output  1  FIFO full; a write is accepted only when full=0
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries queued, excluding the frame in flight
overflow  output  1  one-cycle pulse when en_data_in=1 while full=1
TX  output  1  serial line
busy  output  1  1 from frame load until the last stop bit completes

Behaviour:
- Reset (res=1, asynchronous): TX=1, busy=0, full=0, fifo_count=0, overflow=0. FIFO pointers clear, baud counter=0, FSM=IDLE.
- Reset asserted mid-frame: TX returns to 1 immediately and queued data is discarded.
- Write path: en_data_in && !full pushes data_in at that edge. en_data_in && full drops the byte, leaves FIFO contents unchanged and raises overflow for exactly one cycle.
- full and fifo_count are registered and reflect the state after the current edge.
- Simultaneous push and pop: count unchanged. full is evaluated before the pop, so a write in a cycle where full=1 is rejected even if a pop occurs in the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX=1, busy=0. When the FIFO is non-empty, pop the head into the shift register, set busy=1 and go to START. TX goes low on the edge after the pop. Write-to-TX-low latency from an empty FIFO is 2 cycles.
- Every bit, including the first start bit, is held for exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1; the bit advances on the terminal count and the counter wraps to 0.
- START: TX=0 for one bit, then DATA.
- DATA: shift out DATA_BITS bits LSB-first. A bit index counter selects the next state after the last bit: PARITY if PARITY!=0, otherwise STOP.
- PARITY: TX = XOR of the data bits for even parity, inverted for odd parity.
- STOP: TX=1 for STOP_BITS bit-times.
- At the end of STOP: if the FIFO is non-empty, pop and go directly to START in the same edge, giving zero idle gap between frames with busy staying 1. Otherwise go to IDLE with busy=0.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) x CLKS_PER_BIT cycles.
- Illegal FSM encodings return to IDLE with TX=1.
- en_data_in has no effect on a frame already in flight.

Decomposition:
- Shared package uart_pkg holds:
  - parity encoding constants PAR_NONE/PAR_ODD/PAR_EVEN
  - FSM state localparams
  - a clog2 helper function
- Natural sub-module: uart_tx_fifo, a synchronous FIFO parametrised by width/depth with push, pop, full, empty and count outputs. The top-level module contains the FSM, baud counter and shift register.

Test Plan:
All scenarios use CLK_FREQ=16, BAUD=1 (CLKS_PER_BIT=16) for sim speed.
1. Basic 8N1: reset, write 0x53 once. TX low 2 cycles after the write, then bits 0,1,1,0,0,1,0,1,0,1, each exactly 16 cycles. busy=1 for 160 cycles, then TX=1 and busy=0.
2. Parity: PARITY=2 with 0x53 (four ones) gives parity bit 0; PARITY=1 gives parity bit 1. Frame is 176 cycles.
3. Back-to-back: write 0x53 then 0xA5 on consecutive cycles. Stop bit of frame 1 is followed immediately by the start bit of frame 2, with no idle cycle. busy stays 1 for 320 cycles.
4. Overflow: FIFO_DEPTH=4, write 0x01..0x06 on six consecutive cycles. 0x01 is popped at the second write cycle, 0x02..0x05 are queued, full=1 after the fifth write, the sixth write is rejected with a one-cycle overflow pulse, and exactly five frames 0x01..0x05 are transmitted.
5. Reset mid-frame: assert res during data bit 3. TX=1, busy=0 and fifo_count=0 immediately without waiting for a clock. After release, no residual frame is sent; a fresh write of 0x53 transmits correctly.
6. Variant: DATA_BITS=7, STOP_BITS=2, write 0x7F. Frame is start 0, seven 1s, two stop 1s, 160 cycles total.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity codes, FSM states and a
// constant-safe ceil(log2) helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // Number of bits needed to index 'value' entries (ceil(log2(value))).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Host-side interface of the UART transmitter: write port, FIFO status and the serial line.
interface uart_tx_param_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CountW = clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] data_in;
  logic                 en_data_in;
  logic                 full;
  logic [CountW-1:0]    fifo_count;
  logic                 overflow;
  logic                 TX;
  logic                 busy;

  modport master (
    output data_in, en_data_in,
    input  full, fifo_count, overflow, TX, busy
  );

  modport slave (
    input  data_in, en_data_in,
    output full, fifo_count, overflow, TX, busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered occupancy; head word is presented combinationally on rdata.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    push,
  input  logic                    pop,
  input  logic [Width-1:0]        wdata,
  output logic [Width-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(Depth):0]   count
);
  localparam int unsigned PtrW   = clog2(Depth);
  localparam int unsigned CountW = PtrW + 1;

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CountW'(Depth));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: input FIFO feeding a start/data/parity/stop framing FSM.
// TX is registered from the current state, so the line lags the state by one clock.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 24000000,
  parameter int unsigned BAUD       = 4800,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           res,
  uart_tx_param_if.slave bus
);
  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned CntW       = clog2(ClksPerBit);
  localparam int unsigned IdxW       = clog2(DATA_BITS + 1);
  localparam int unsigned CountW     = clog2(FIFO_DEPTH) + 1;
  localparam logic        HasPar     = (PARITY != PAR_NONE);
  localparam logic        OddPar     = (PARITY == PAR_ODD);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 busy_q, busy_d;
  logic                 tx_q, tx_d;
  logic                 overflow_q;
  logic                 tick;
  logic                 push, pop;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic [CountW-1:0]    fifo_cnt;

  // Full is the registered pre-pop value, so a write while full is rejected even on a pop cycle.
  assign push = bus.en_data_in && !fifo_full;

  uart_tx_fifo #(
    .Width (DATA_BITS),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (push),
    .pop   (pop),
    .wdata (bus.data_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign tick = (cnt_q == CntW'(ClksPerBit - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    busy_d  = busy_q;
    tx_d    = 1'b1;
    pop     = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d  = '0;
        busy_d = 1'b0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          busy_d  = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (tick) begin
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        tx_d = shreg_q[0];
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == IdxW'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = HasPar ? StParity : StStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        tx_d = par_q;
        if (tick) begin
          idx_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (tick) begin
          if (idx_q == IdxW'(STOP_BITS - 1)) begin
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = StStart;
            end else begin
              busy_d  = 1'b0;
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase

    if (pop) begin
      shreg_d = fifo_rdata;
      par_d   = (^fifo_rdata) ^ OddPar;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      busy_q     <= 1'b0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      busy_q     <= busy_d;
      tx_q       <= tx_d;
      overflow_q <= bus.en_data_in && fifo_full;
    end
  end

  assign bus.TX         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.full       = fifo_full;
  assign bus.fifo_count = fifo_cnt;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four instances (8N1, even parity, odd parity, 7-data/2-stop) at
// 16 clocks per bit; written bytes go to a scoreboard and every TX cycle is compared to it.
module tb_uart_tx_param;

  logic clk;
  logic res;

  int tests_run;
  int tests_failed;
  int cur_sel;
  int busy_total;

  logic [8:0] sb_q[$];

  uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_a ();
  uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_e ();
  uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_o ();
  uart_tx_param_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if_v ();

  uart_tx_param #(
    .CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (.clk(clk), .res(res), .bus(if_a));

  uart_tx_param #(
    .CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_e (.clk(clk), .res(res), .bus(if_e));

  uart_tx_param #(
    .CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_o (.clk(clk), .res(res), .bus(if_o));

  uart_tx_param #(
    .CLK_FREQ(16), .BAUD(1), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_v (.clk(clk), .res(res), .bus(if_v));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic tx_of(input int sel);
    case (sel)
      0:       return if_a.TX;
      1:       return if_e.TX;
      2:       return if_o.TX;
      default: return if_v.TX;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return if_a.busy;
      1:       return if_e.busy;
      2:       return if_o.busy;
      default: return if_v.busy;
    endcase
  endfunction

  always @(negedge clk) begin
    if (busy_of(cur_sel) === 1'b1) busy_total <= busy_total + 1;
  end

  task automatic drive(input int sel, input logic en, input logic [8:0] d);
    case (sel)
      0:       begin if_a.en_data_in = en; if_a.data_in = d[7:0]; end
      1:       begin if_e.en_data_in = en; if_e.data_in = d[7:0]; end
      2:       begin if_o.en_data_in = en; if_o.data_in = d[7:0]; end
      default: begin if_v.en_data_in = en; if_v.data_in = d[6:0]; end
    endcase
  endtask

  // Single write; returns on the negedge right after the accepting clock edge.
  task automatic write_one(input int sel, input logic [8:0] d);
    @(negedge clk);
    drive(sel, 1'b1, d);
    sb_q.push_back(d);
    @(negedge clk);
    drive(sel, 1'b0, 9'h0);
  endtask

  // Waits for a start bit, then checks every cycle of the frame against the scoreboard head.
  task automatic rx_frame(input int sel, input string name, output int gap);
    int nb, np, ns, len, errs, first_bad;
    logic [8:0] exp_d, got, mask;
    logic [12:0] stream;
    logic s;
    nb = (sel == 3) ? 7 : 8;
    np = (sel == 1 || sel == 2) ? 1 : 0;
    ns = (sel == 3) ? 2 : 1;
    len = (1 + nb + np + ns) * 16;
    gap = 0;
    while (tx_of(sel) !== 1'b0 && gap < 2000) begin
      @(negedge clk);
      gap++;
    end
    tests_run++;
    if (tx_of(sel) !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s start: TX=%b after %0d cycles, required 0", name, tx_of(sel), gap);
      return;
    end
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s scoreboard: frame seen with %0d entries queued, required >=1",
               name, sb_q.size());
      return;
    end
    exp_d = sb_q.pop_front();
    mask = 9'((32'd1 << nb) - 1);
    stream = '1;
    stream[0] = 1'b0;
    for (int k = 0; k < nb; k++) stream[1+k] = exp_d[k];
    if (np != 0) stream[1+nb] = (sel == 1) ? ^exp_d[7:0] : ~^exp_d[7:0];
    errs = 0;
    first_bad = -1;
    got = '0;
    for (int i = 0; i < len; i++) begin
      s = tx_of(sel);
      if (s !== stream[i/16]) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
      if ((i % 16) == 8 && (i / 16) >= 1 && (i / 16) <= nb) got[i/16-1] = s;
      @(negedge clk);
    end
    if (errs != 0 || got !== (exp_d & mask)) begin
      tests_failed++;
      $display("FAIL %s frame: got 0x%0h with %0d bad cycles (first at %0d), required 0x%0h",
               name, got, errs, first_bad, exp_d & mask);
    end
  endtask

  task automatic test_reset;
    res = 1'b1;
    repeat (3) @(negedge clk);
    tests_run += 6;
    if (if_a.TX !== 1'b1) begin
      tests_failed++; $display("FAIL reset_tx: %b required 1", if_a.TX);
    end
    if (if_a.busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: %b required 0", if_a.busy);
    end
    if (if_a.full !== 1'b0) begin
      tests_failed++; $display("FAIL reset_full: %b required 0", if_a.full);
    end
    if (if_a.fifo_count !== 3'd0) begin
      tests_failed++; $display("FAIL reset_count: %0d required 0", if_a.fifo_count);
    end
    if (if_a.overflow !== 1'b0) begin
      tests_failed++; $display("FAIL reset_overflow: %b required 0", if_a.overflow);
    end
    if (if_v.TX !== 1'b1) begin
      tests_failed++; $display("FAIL reset_tx_v: %b required 1", if_v.TX);
    end
    res = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (if_a.TX !== 1'b1 || if_a.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: TX=%b busy=%b required TX=1 busy=0", if_a.TX, if_a.busy);
    end
  endtask

  task automatic check_busy(input string name, input int start, input int required);
    tests_run++;
    if (busy_total - start != required) begin
      tests_failed++;
      $display("FAIL %s busy_cycles: %0d required %0d", name, busy_total - start, required);
    end
  endtask

  task automatic test_basic;
    int gap, b0;
    cur_sel = 0;
    @(negedge clk);
    b0 = busy_total;
    write_one(0, 9'h53);
    rx_frame(0, "basic", gap);
    tests_run++;
    if (gap != 2) begin
      tests_failed++; $display("FAIL basic_latency: %0d cycles required 2", gap);
    end
    repeat (2) @(negedge clk);
    check_busy("basic", b0, 160);
    tests_run++;
    if (if_a.TX !== 1'b1 || if_a.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_idle: TX=%b busy=%b required TX=1 busy=0", if_a.TX, if_a.busy);
    end
  endtask

  task automatic test_parity;
    int gap, b0;
    for (int sel = 1; sel <= 2; sel++) begin
      cur_sel = sel;
      @(negedge clk);
      b0 = busy_total;
      write_one(sel, 9'h53);
      rx_frame(sel, (sel == 1) ? "parity_even" : "parity_odd", gap);
      repeat (2) @(negedge clk);
      check_busy((sel == 1) ? "parity_even" : "parity_odd", b0, 176);
    end
  endtask

  task automatic test_back_to_back;
    int g1, g2, b0;
    cur_sel = 0;
    @(negedge clk);
    b0 = busy_total;
    fork
      begin
        @(negedge clk); drive(0, 1'b1, 9'h53); sb_q.push_back(9'h53);
        @(negedge clk); drive(0, 1'b1, 9'hA5); sb_q.push_back(9'hA5);
        @(negedge clk); drive(0, 1'b0, 9'h0);
      end
      begin
        rx_frame(0, "b2b_first", g1);
        rx_frame(0, "b2b_second", g2);
      end
    join
    tests_run++;
    if (g2 != 0) begin
      tests_failed++; $display("FAIL b2b_gap: %0d idle cycles required 0", g2);
    end
    repeat (2) @(negedge clk);
    check_busy("b2b", b0, 320);
  endtask

  task automatic test_overflow;
    int g[5];
    cur_sel = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (i == 4) begin
            tests_run++;
            if (if_a.full !== 1'b0 || if_a.fifo_count !== 3'd3) begin
              tests_failed++;
              $display("FAIL ovf_before_fifth: full=%b count=%0d required full=0 count=3",
                       if_a.full, if_a.fifo_count);
            end
          end
          if (i == 5) begin
            tests_run++;
            if (if_a.full !== 1'b1 || if_a.fifo_count !== 3'd4) begin
              tests_failed++;
              $display("FAIL ovf_full: full=%b count=%0d required full=1 count=4",
                       if_a.full, if_a.fifo_count);
            end
          end
          drive(0, 1'b1, 9'(i + 1));
          if (i < 5) sb_q.push_back(9'(i + 1));
        end
        @(negedge clk);
        drive(0, 1'b0, 9'h0);
        tests_run++;
        if (if_a.overflow !== 1'b1 || if_a.fifo_count !== 3'd4) begin
          tests_failed++;
          $display("FAIL ovf_pulse: overflow=%b count=%0d required overflow=1 count=4",
                   if_a.overflow, if_a.fifo_count);
        end
        @(negedge clk);
        tests_run++;
        if (if_a.overflow !== 1'b0) begin
          tests_failed++; $display("FAIL ovf_pulse_width: %b required 0", if_a.overflow);
        end
      end
      begin
        for (int f = 0; f < 5; f++) rx_frame(0, "ovf_frame", g[f]);
      end
    join
    for (int f = 1; f < 5; f++) begin
      tests_run++;
      if (g[f] != 0) begin
        tests_failed++; $display("FAIL ovf_gap: frame %0d gap %0d required 0", f, g[f]);
      end
    end
    repeat (40) @(negedge clk);
    tests_run++;
    if (if_a.busy !== 1'b0 || if_a.TX !== 1'b1 || sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL ovf_no_sixth: busy=%b TX=%b pending=%0d required busy=0 TX=1 pending=0",
               if_a.busy, if_a.TX, sb_q.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    int lows, gap;
    cur_sel = 0;
    @(negedge clk); drive(0, 1'b1, 9'h53); sb_q.push_back(9'h53);
    @(negedge clk); drive(0, 1'b1, 9'h11); sb_q.push_back(9'h11);
    @(negedge clk); drive(0, 1'b0, 9'h0);
    repeat (72) @(negedge clk);
    tests_run++;
    if (if_a.TX !== 1'b0 || if_a.busy !== 1'b1 || if_a.fifo_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL mid_before: TX=%b busy=%b count=%0d required TX=0 busy=1 count=1",
               if_a.TX, if_a.busy, if_a.fifo_count);
    end
    res = 1'b1;
    #1;
    tests_run++;
    if (if_a.TX !== 1'b1 || if_a.busy !== 1'b0 || if_a.fifo_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL mid_async: TX=%b busy=%b count=%0d required TX=1 busy=0 count=0",
               if_a.TX, if_a.busy, if_a.fifo_count);
    end
    sb_q.delete();
    @(negedge clk);
    res = 1'b0;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (if_a.TX !== 1'b1) lows++;
    end
    tests_run++;
    if (lows != 0) begin
      tests_failed++; $display("FAIL mid_residual: %0d low cycles required 0", lows);
    end
    write_one(0, 9'h53);
    rx_frame(0, "mid_fresh", gap);
    tests_run++;
    if (gap != 2) begin
      tests_failed++; $display("FAIL mid_fresh_latency: %0d cycles required 2", gap);
    end
  endtask

  task automatic test_variant;
    int gap, b0;
    cur_sel = 3;
    @(negedge clk);
    b0 = busy_total;
    write_one(3, 9'h7F);
    rx_frame(3, "variant", gap);
    repeat (2) @(negedge clk);
    check_busy("variant", b0, 160);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    cur_sel = 0;
    busy_total = 0;
    res = 1'b1;
    for (int s = 0; s < 4; s++) drive(s, 1'b0, 9'h0);
    test_reset;
    test_basic;
    test_parity;
    test_back_to_back;
    test_overflow;
    test_reset_mid_frame;
    test_variant;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached with %0d tests run, required completion",
             tests_run);
    $fatal(1, "watchdog");
  end

endmodule
